// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with programmable wait states and RV32I sized access
//
// Ports:
//   clk, rst              clock; asynchronous active-low reset
//   req_valid/req_ready   request handshake (req_ready registered, high only in IDLE)
//   req_we                1 = store, 0 = load
//   req_funct3            RV32I size/extension (B, H, W, BU, HU)
//   req_addr, req_wdata   byte address and store data
//   rsp_valid/rsp_ready   response handshake; outputs held stable under backpressure
//   rsp_rdata             extended load data, 0 for stores and rejected requests
//   rsp_err               misaligned, out-of-range or illegal funct3

module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        cap_we;
    logic [2:0]  cap_funct3;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;

    // Storage is deliberately not reset.
    logic [31:0] mem [DEPTH_WORDS];

    logic [AW-1:0] word_idx;
    logic [1:0]    lane;
    logic [31:0]   cur_word;
    logic [7:0]    sel_byte;
    logic [15:0]   sel_half;
    logic          access;
    logic          acc_err;
    logic [31:0]   load_data;
    logic [3:0]    wr_mask;
    logic [31:0]   wr_data;

    assign word_idx = cap_addr[AW+1:2];
    assign lane     = cap_addr[1:0];
    assign access   = (state == ST_WAIT) && (cnt == 4'd0);

    always_comb begin
        cur_word  = mem[word_idx];
        sel_byte  = cur_word[{lane, 3'b000} +: 8];
        sel_half  = cap_addr[1] ? cur_word[31:16] : cur_word[15:0];

        acc_err   = 1'b0;
        load_data = 32'd0;
        wr_mask   = 4'b0000;
        wr_data   = cap_wdata;

        case (cap_funct3)
            3'b000, 3'b100: acc_err = 1'b0;
            3'b001, 3'b101: acc_err = cap_addr[0];
            3'b010:         acc_err = (cap_addr[1:0] != 2'b00);
            default:        acc_err = 1'b1;
        endcase
        // Unsigned variants (and the illegal 11x codes) are never valid for stores.
        if (cap_we && cap_funct3[2]) begin
            acc_err = 1'b1;
        end
        if ({1'b0, cap_addr} >= BYTE_LIMIT) begin
            acc_err = 1'b1;
        end

        case (cap_funct3)
            3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  load_data = {24'd0, sel_byte};
            3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
            3'b101:  load_data = {16'd0, sel_half};
            3'b010:  load_data = cur_word;
            default: load_data = 32'd0;
        endcase

        // Store data is replicated across lanes so the mask alone selects the target bytes.
        case (cap_funct3[1:0])
            2'b00: begin
                wr_mask = 4'b0001 << lane;
                wr_data = {4{cap_wdata[7:0]}};
            end
            2'b01: begin
                wr_mask = cap_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{cap_wdata[15:0]}};
            end
            default: begin
                wr_mask = 4'b1111;
                wr_data = cap_wdata;
            end
        endcase
    end

    // Commit is qualified by the asynchronously reset state, so a reset before
    // the access edge drops the pending store.
    always_ff @(posedge clk) begin
        if (access && cap_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_mask[i]) begin
                    mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'd0;
            rsp_err    <= 1'b0;
            cap_we     <= 1'b0;
            cap_funct3 <= 3'd0;
            cap_addr   <= 32'd0;
            cap_wdata  <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        cap_we     <= req_we;
                        cap_funct3 <= req_funct3;
                        cap_addr   <= req_addr;
                        cap_wdata  <= req_wdata;
                        cnt        <= WAIT_INIT;
                        req_ready  <= 1'b0;
                        state      <= ST_WAIT;
                    end else begin
                        req_ready  <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= acc_err;
                        rsp_rdata <= (acc_err || cap_we) ? 32'd0 : load_data;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'd0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the core's data-memory port. It accepts one load or store request at a time over a valid/ready handshake and applies a programmable number of wait states. It performs byte, halfword or word access with RV32I funct3 sizing and sign/zero extension, and returns the result over a valid/ready response channel. It replaces the zero-latency DMEM model, so the write-back stage can be exercised against realistic memory latency.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words stored; legal byte addresses are 0 .. 4*DEPTH_WORDS-1.
- WAIT_CYCLES, 2: wait states inserted before each access; 0..15 legal.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request offered by core.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  access size/extension: 000 B, 001 H, 010 W, 100 BU (load only), 101 HU (load only).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; byte/halfword taken from low bits.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  core accepts response.
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- rsp_err  out  1  request was rejected (misaligned, out of range, illegal funct3).

## Operation
- States:
  - IDLE: req_ready=1. Handshake (req_valid & req_ready) captures we, funct3, addr and wdata into registers, loads cnt=WAIT_CYCLES, and moves to WAIT.
  - WAIT: if cnt!=0, decrement; if cnt==0, perform the access, load the response registers, and move to RESP.
  - RESP: rsp_valid=1 and outputs are held stable until rsp_ready. On the handshake, move to IDLE.
- Error check, evaluated on captured request in the access cycle:
  - addr >= 4*DEPTH_WORDS: error.
  - H/HU with addr[0]=1: misaligned.
  - W with addr[1:0]!=0: misaligned.
  - funct3 in {011,110,111}: illegal.
  - Store with funct3 100/101: illegal.
  - On any error, no memory write occurs, rsp_err=1 and rsp_rdata=0.
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Byte lane = addr[1:0]. Halfword lane = addr[1].
- Store: SB writes only lane addr[1:0] with wdata[7:0]; SH writes lanes {addr[1],0..1} with wdata[15:0]; SW writes all 4. Other bytes unchanged.
- Load: B/H sign-extend bit 7/15 of the selected lane; BU/HU zero-extend; W returns the word.
- Memory array is not reset; contents are undefined until written.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE, cnt=0.
- req_ready is registered. It rises on the first clk edge after rst deasserts, falls on the accept edge, and rises on the edge after the response handshake.
- Latency: accept at edge E. Access and rsp_valid rise at edge E+WAIT_CYCLES+1.
- Store commit happens at that same edge. A load issued after the store's response handshake sees the new data.
- Minimum request spacing is WAIT_CYCLES+3 cycles: accept, WAIT_CYCLES+1 cycles in WAIT, at least one cycle in RESP, and one cycle back in IDLE.
- Accept and response never overlap, because req_ready=0 outside IDLE.
- Backpressure: rsp_valid stays high with rsp_rdata/rsp_err constant for any number of cycles with rsp_ready=0.
- req_* inputs are don't-care outside the accept cycle.
- Reset mid-transaction immediately clears all outputs and returns to IDLE. A store not yet at its commit edge is dropped, and no response is produced.

## Test plan
- Reset, then SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0. rsp_valid rises exactly WAIT_CYCLES+1 edges after each accept.
- After that word is stored: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
- SB 0x11 data 0x00000055 over 0xDEADBEEF, then LW 0x10 -> 0xDEAD55EF. SH 0x12 data 0x1234, then LW 0x10 -> 0x123455EF.
- Error cases each give rsp_err=1, rsp_rdata=0, and memory is unchanged (verified by a following LW):
  - LW 0x11 (misaligned);
  - LH 0x13 (misaligned);
  - SW 4*DEPTH_WORDS (out of range);
  - funct3=011 (illegal);
  - store with funct3=100 (illegal).
- Hold rsp_ready=0 for 7 cycles on a load -> rsp_valid and rsp_rdata are stable, and req_ready stays 0 throughout. Releasing rsp_ready gives req_ready=1 on the next cycle.
- Accept SW 0x20 data 0x11111111, then assert rst during WAIT before the commit edge -> all outputs 0, and no response. After reset release, LW 0x20 returns the prior contents, not 0x11111111. Repeat with WAIT_CYCLES=0 and check latency is 1 edge.
